// File: rtl/ff_event_delay_stage.sv
// Registers d to q every clock; captures load_val on load and commits it to a after REPEAT_N toggle events.
// Latency: q one clock; a valid one clock after the REPEAT_N-th event. Loads while busy are ignored.
module ff_event_delay_stage #(
  parameter int              WIDTH    = 1,
  parameter int              REPEAT_N = 2,
  parameter logic [WIDTH-1:0] A_RST   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic             ev_tgl,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [7:0]       ev_cnt
);

  generate
    if (REPEAT_N < 1 || REPEAT_N > 255) begin : g_bad_repeat
      $error("ff_event_delay_stage: REPEAT_N must be in 1..255");
    end
  endgenerate

  localparam logic [8:0] RepeatN9 = 9'(REPEAT_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ev_q;
  logic             ev;
  logic [WIDTH-1:0] hold;
  logic [8:0]       ev_cnt_inc;

  // ev_q resets to 0; the first post-reset edge always finds the FSM idle, so a
  // stale toggle level seen there can never be counted.
  assign ev         = ev_tgl ^ ev_q;
  assign ev_cnt_inc = {1'b0, ev_cnt} + 9'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = WAIT;
      WAIT:    if (ev && ev_cnt_inc == RepeatN9) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      a      <= A_RST;
      hold   <= '0;
      ev_q   <= 1'b0;
      ev_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      q     <= d;
      ev_q  <= ev_tgl;
      if (state == IDLE && load) begin
        hold   <= load_val;
        ev_cnt <= 8'd0;
      end
      if (state == WAIT && ev && ev_cnt != 8'hFF) begin
        ev_cnt <= ev_cnt_inc[7:0];
      end
      if (state == COMMIT) begin
        a <= hold;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == COMMIT);

endmodule

// File: tb/tb_ff_event_delay_stage.sv
// Bench for ff_event_delay_stage: directed cycle checks plus a commit-value scoreboard
// for a REPEAT_N=2 instance and a REPEAT_N=1 instance.
module tb_ff_event_delay_stage;

  localparam int W = 8;
  localparam logic [W-1:0] A_RST1 = 8'hA5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] d;
  logic         ev_tgl;
  logic         load2, load1;
  logic [W-1:0] load_val;
  logic [W-1:0] q2, q1, a2, a1;
  logic         busy2, busy1, done2, done1;
  logic [7:0]   ev_cnt2, ev_cnt1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb2[$];
  logic [W-1:0] sb1[$];

  always #5 clk = ~clk;

  ff_event_delay_stage #(.WIDTH(W), .REPEAT_N(2), .A_RST(8'h00)) dut2 (
    .clk(clk), .rst_n(rst_n), .d(d), .q(q2), .ev_tgl(ev_tgl), .load(load2),
    .load_val(load_val), .a(a2), .busy(busy2), .done(done2), .ev_cnt(ev_cnt2)
  );

  ff_event_delay_stage #(.WIDTH(W), .REPEAT_N(1), .A_RST(A_RST1)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .q(q1), .ev_tgl(ev_tgl), .load(load1),
    .load_val(load_val), .a(a1), .busy(busy1), .done(done1), .ev_cnt(ev_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A done pulse means the value at the front of the queue lands on a at the next edge.
  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (sb2.size() == 0) begin
        check("dut2_unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] exp2;
        exp2 = sb2.pop_front();
        @(posedge clk);
        #1;
        check("dut2_sb_commit", a2, exp2);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (sb1.size() == 0) begin
        check("dut1_unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] exp1;
        exp1 = sb1.pop_front();
        @(posedge clk);
        #1;
        check("dut1_sb_commit", a1, exp1);
      end
    end
  end

  initial begin
    logic [W-1:0] pipe_vals[3];
    pipe_vals[0] = 8'h01;
    pipe_vals[1] = 8'h00;
    pipe_vals[2] = 8'h01;

    // Reset held with load and a high toggle line
    rst_n = 1'b0; d = 8'hFF; ev_tgl = 1'b1; load2 = 1'b1; load1 = 1'b1; load_val = 8'hEE;
    repeat (3) tick();
    check("rst_q", q2, 0);
    check("rst_a", a2, 0);
    check("rst_a1", a1, A_RST1);
    check("rst_busy", busy2, 0);
    check("rst_done", done2, 0);
    check("rst_ev_cnt", ev_cnt2, 0);
    rst_n = 1'b1; load2 = 1'b0; load1 = 1'b0; d = 8'h00;
    tick();
    check("post_rst_busy", busy2, 0);
    check("post_rst_ev_cnt", ev_cnt2, 0);

    // Pipeline
    for (int i = 0; i < 3; i++) begin
      d = pipe_vals[i];
      tick();
      check("pipe_q", q2, pipe_vals[i]);
    end

    // Delay with REPEAT_N=2
    load2 = 1'b1; load_val = 8'h01; sb2.push_back(8'h01);
    tick();
    load2 = 1'b0;
    check("dly_busy_after_load", busy2, 1);
    check("dly_done_after_load", done2, 0);
    repeat (2) tick();
    check("dly_no_ev_cnt", ev_cnt2, 0);
    ev_tgl = ~ev_tgl;
    tick();
    check("dly_ev1_cnt", ev_cnt2, 1);
    check("dly_ev1_done", done2, 0);
    repeat (3) tick();
    check("dly_gap_busy", busy2, 1);
    ev_tgl = ~ev_tgl;
    tick();
    check("dly_commit_done", done2, 1);
    check("dly_commit_busy", busy2, 1);
    check("dly_commit_a_old", a2, 0);
    tick();
    check("dly_a", a2, 8'h01);
    check("dly_done_clear", done2, 0);
    check("dly_busy_clear", busy2, 0);
    check("dly_cnt_hold", ev_cnt2, 2);

    // Load and toggle on the same edge; extra load while waiting
    load2 = 1'b1; load_val = 8'h77; ev_tgl = ~ev_tgl; sb2.push_back(8'h77);
    tick();
    check("edge_same_cnt", ev_cnt2, 0);
    load_val = 8'h88; ev_tgl = ~ev_tgl;
    tick();
    check("edge_extra_load_cnt", ev_cnt2, 1);
    check("edge_extra_load_a", a2, 8'h01);
    load2 = 1'b0; ev_tgl = ~ev_tgl;
    tick();
    check("edge_commit_done", done2, 1);
    ev_tgl = ~ev_tgl;
    tick();
    check("edge_hold_kept", a2, 8'h77);
    check("edge_commit_ev_dropped", ev_cnt2, 2);
    tick();
    check("edge_idle_cnt", ev_cnt2, 2);

    // Reset in the middle of a wait
    load2 = 1'b1; load_val = 8'h3C;
    tick();
    load2 = 1'b0; ev_tgl = ~ev_tgl;
    tick();
    check("mid_cnt_before_rst", ev_cnt2, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", a2, 0);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_done", done2, 0);
    check("mid_rst_cnt", ev_cnt2, 0);
    check("mid_rst_a1", a1, A_RST1);
    tick();
    rst_n = 1'b1;
    ev_tgl = ~ev_tgl;
    repeat (3) tick();
    check("mid_after_busy", busy2, 0);
    check("mid_after_a", a2, 0);

    // Back-to-back commits with REPEAT_N=1
    load1 = 1'b1; load_val = 8'h11; sb1.push_back(8'h11);
    tick();
    load1 = 1'b0; ev_tgl = ~ev_tgl;
    tick();
    check("b2b_done1", done1, 1);
    tick();
    check("b2b_a1_first", a1, 8'h11);
    load1 = 1'b1; load_val = 8'h22; sb1.push_back(8'h22);
    tick();
    load1 = 1'b0;
    check("b2b_cnt_restart", ev_cnt1, 0);
    check("b2b_busy", busy1, 1);
    ev_tgl = ~ev_tgl;
    tick();
    check("b2b_done2", done1, 1);
    check("b2b_cnt", ev_cnt1, 1);
    tick();
    check("b2b_a1_second", a1, 8'h22);
    check("b2b_dut2_idle", busy2, 0);

    repeat (3) tick();
    check("sb2_empty", sb2.size(), 0);
    check("sb1_empty", sb1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
